// File: rtl/sram_like_arbiter.sv
// Arbitrates one sram-like port between inst and data masters, one transaction in flight.
// Data wins by default; after MAX_DATA_STREAK data grants with inst waiting, inst goes next.
module sram_like_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int CNT_W           = 3
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DATA_STREAK);

  logic [1:0]       state;
  logic             owner;
  logic [CNT_W-1:0] streak;

  logic sel_data;
  logic grant;
  logic cur_owner;
  logic owner_req;
  logic req_int;
  logic accept;
  logic done;

  // Inst is forced through only once the streak cap is hit and inst is actually waiting.
  always_comb begin
    sel_data = data_req & ~(inst_req & (streak == STREAK_MAX) & (MAX_DATA_STREAK != 0));
    grant    = data_req | inst_req;
  end

  always_comb begin
    cur_owner = (state == IDLE) ? sel_data : owner;
    owner_req = cur_owner ? data_req : inst_req;
    case (state)
      IDLE:    req_int = grant;
      ADDR:    req_int = owner_req;
      default: req_int = 1'b0;
    endcase
    accept = req_int & mem_addr_ok;
    done   = (state == DATA) & mem_data_ok;
  end

  // Outputs are forced to zero combinationally so they clear the moment reset asserts.
  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = 2'd0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = 32'd0;
    data_rdata   = 32'd0;
    if (rst) begin
      mem_req      = req_int;
      mem_wr       = cur_owner ? data_wr    : inst_wr;
      mem_size     = cur_owner ? data_size  : inst_size;
      mem_addr     = cur_owner ? data_addr  : inst_addr;
      mem_wdata    = cur_owner ? data_wdata : inst_wdata;
      inst_addr_ok = accept & ~cur_owner;
      data_addr_ok = accept &  cur_owner;
      inst_data_ok = done & ~owner;
      data_data_ok = done &  owner;
      inst_rdata   = mem_rdata;
      data_rdata   = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner <= sel_data;
            state <= mem_addr_ok ? DATA : ADDR;
          end
        end
        ADDR: begin
          // A master withdrawing its request before acceptance simply abandons it.
          if (!owner_req)       state <= IDLE;
          else if (mem_addr_ok) state <= DATA;
        end
        DATA: begin
          if (mem_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= '0;
    end else if (accept) begin
      if (cur_owner && inst_req)
        streak <= (streak == STREAK_MAX) ? STREAK_MAX : streak + 1'b1;
      else
        streak <= '0;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: reset gating, priority/streak, ownership lock, reset abort.
module tb_sram_like_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int nvec = 0;
  int nerr = 0;

  sram_like_arbiter #(.MAX_DATA_STREAK(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [9:0] pat;

  initial begin
    rst = 1'b0;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2;
    inst_addr = 32'hbfc00000; inst_wdata = 32'h11111111;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h00001000; data_wdata = 32'h22222222;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hdeadbeef;

    // Reset: everything zero despite active inputs
    tick(); tick();
    chk("rst_mem_req",   {31'd0, mem_req},      32'd0);
    chk("rst_mem_wr",    {31'd0, mem_wr},       32'd0);
    chk("rst_mem_addr",  mem_addr,              32'd0);
    chk("rst_mem_wdata", mem_wdata,             32'd0);
    chk("rst_mem_size",  {30'd0, mem_size},     32'd0);
    chk("rst_addr_ok",   {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    chk("rst_data_ok",   {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("rst_inst_rdata", inst_rdata,           32'd0);
    chk("rst_data_rdata", data_rdata,           32'd0);

    inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    rst = 1'b1;
    tick();

    // 1: single inst read
    inst_req = 1'b1; mem_addr_ok = 1'b1; settle();
    chk("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t1_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    chk("t1_mem_addr",     mem_addr,              32'hbfc00000);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0; settle();
    chk("t1_c1_mem_req",   {31'd0, mem_req},      32'd0);
    chk("t1_c1_data_ok",   {31'd0, inst_data_ok}, 32'd0);
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'h24020001; settle();
    chk("t1_c2_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("t1_c2_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    chk("t1_c2_inst_rdata",   inst_rdata,            32'h24020001);
    chk("t1_c2_data_rdata",   data_rdata,            32'h24020001);
    tick();
    mem_data_ok = 1'b0; settle();
    chk("t1_c3_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("t1_c3_mem_req",      {31'd0, mem_req},      32'd0);

    // 2: simultaneous requests, data first
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1; mem_addr_ok = 1'b1; settle();
    chk("t2_mem_addr",      mem_addr,              32'h00001000);
    chk("t2_mem_wr",        {31'd0, mem_wr},       32'd1);
    chk("t2_data_addr_ok",  {31'd0, data_addr_ok}, 32'd1);
    chk("t2_inst_addr_ok",  {31'd0, inst_addr_ok}, 32'd0);
    tick();
    data_req = 1'b0; data_wr = 1'b0; mem_data_ok = 1'b1; settle();
    chk("t2_data_phase_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("t2_data_phase_mem_req",      {31'd0, mem_req},      32'd0);
    chk("t2_data_data_ok",            {31'd0, data_data_ok}, 32'd1);
    chk("t2_inst_data_ok",            {31'd0, inst_data_ok}, 32'd0);
    tick();
    mem_data_ok = 1'b0; settle();
    chk("t2_inst_grant",    {31'd0, inst_addr_ok}, 32'd1);
    chk("t2_inst_mem_addr", mem_addr,              32'hbfc00000);
    tick();
    mem_data_ok = 1'b1; settle();
    chk("t2_inst_done",     {31'd0, inst_data_ok}, 32'd1);
    tick();

    // 3: continuous contention, bridge always ready
    pat = 10'b0111101111;
    data_req = 1'b1; inst_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk($sformatf("t3_grant%0d_data", i), {31'd0, data_addr_ok}, {31'd0, pat[i]});
      chk($sformatf("t3_grant%0d_inst", i), {31'd0, inst_addr_ok}, {31'd0, ~pat[i]});
      chk($sformatf("t3_idle%0d_no_ok", i), {30'd0, inst_data_ok, data_data_ok}, 32'd0);
      tick();
      settle();
      chk($sformatf("t3_done%0d", i), {30'd0, inst_data_ok, data_data_ok},
          pat[i] ? 32'd1 : 32'd2);
      tick();
    end
    data_req = 1'b0; inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    tick();

    // 4: inst owns the port while the bridge stalls
    inst_req = 1'b1; inst_addr = 32'hbfc00100; settle();
    chk("t4_c0_mem_req",   {31'd0, mem_req},      32'd1);
    chk("t4_c0_addr_ok",   {31'd0, inst_addr_ok}, 32'd0);
    tick();
    data_req = 1'b1; data_addr = 32'h00002000;
    for (int c = 1; c < 3; c++) begin
      settle();
      chk($sformatf("t4_c%0d_mem_addr", c), mem_addr, 32'hbfc00100);
      chk($sformatf("t4_c%0d_data_addr_ok", c), {31'd0, data_addr_ok}, 32'd0);
      chk($sformatf("t4_c%0d_inst_addr_ok", c), {31'd0, inst_addr_ok}, 32'd0);
      tick();
    end
    mem_addr_ok = 1'b1; settle();
    chk("t4_c3_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t4_c3_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    chk("t4_c3_mem_addr",     mem_addr,              32'hbfc00100);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; settle();
    chk("t4_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    tick();
    mem_data_ok = 1'b0;

    // 5: data byte write through an ADDR stall
    data_wr = 1'b1; data_size = 2'd0; data_addr = 32'hbfaf0000; data_wdata = 32'h000000ab;
    settle();
    chk("t5_idle_mem_req", {31'd0, mem_req}, 32'd1);
    tick();
    mem_addr_ok = 1'b1; settle();
    chk("t5_mem_wr",      {31'd0, mem_wr},       32'd1);
    chk("t5_mem_size",    {30'd0, mem_size},     32'd0);
    chk("t5_mem_addr",    mem_addr,              32'hbfaf0000);
    chk("t5_mem_wdata",   mem_wdata,             32'h000000ab);
    chk("t5_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    tick();
    data_req = 1'b0; data_wr = 1'b0; mem_addr_ok = 1'b0; settle();
    chk("t5_wait_data_ok", {31'd0, data_data_ok}, 32'd0);
    tick();
    mem_data_ok = 1'b1; settle();
    chk("t5_data_data_ok", {31'd0, data_data_ok}, 32'd1);
    tick();
    mem_data_ok = 1'b0; settle();
    chk("t5_pulse_once",   {31'd0, data_data_ok}, 32'd0);

    // 6: reset during DATA, then a stale response
    inst_req = 1'b1; mem_addr_ok = 1'b1; settle();
    chk("t6_accept", {31'd0, inst_addr_ok}, 32'd1);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0; rst = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h12345678;
    settle();
    chk("t6_rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("t6_rst_rdata",   inst_rdata,                          32'd0);
    chk("t6_rst_mem_req", {31'd0, mem_req},                    32'd0);
    tick();
    rst = 1'b1; settle();
    chk("t6_stale_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("t6_rdata_live",    inst_rdata,                          32'h12345678);
    tick();
    mem_data_ok = 1'b0; inst_req = 1'b1; mem_addr_ok = 1'b1; settle();
    chk("t6_regrant", {31'd0, inst_addr_ok}, 32'd1);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; settle();
    chk("t6_regrant_done", {31'd0, inst_data_ok}, 32'd1);
    tick();
    mem_data_ok = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like memory port between the core's instruction-fetch master (inst_*) and data-access master (data_*).
- Sits between the pipelined core and the sram-like-to-AXI bridge.
- Allows one outstanding transaction at a time. Data requests have priority; a bounded-streak rule prevents instruction-fetch starvation.
- Routes addr_ok/data_ok back to the owning master only. Read data is broadcast.

Parameters:
- MAX_DATA_STREAK, 4: number of consecutive data grants made while inst_req is pending, after which the next grant goes to inst. 0 = pure data priority.
- CNT_W, 3: width of the streak counter. Must satisfy 2^CNT_W > MAX_DATA_STREAK.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- inst_req  in  1  instruction master request
- inst_wr  in  1  write flag (normally 0)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  32  byte address
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  inst request accepted
- inst_data_ok  out  1  inst transaction complete
- inst_rdata  out  32  read data
- data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/32/32  data master request, same meaning as the inst fields
- data_addr_ok, data_data_ok  out  1  data accept / complete
- data_rdata  out  32  read data
- mem_req, mem_wr  out  1  to bridge
- mem_size  out  2  to bridge
- mem_addr, mem_wdata  out  32  to bridge
- mem_addr_ok, mem_data_ok  in  1  from bridge
- mem_rdata  in  32  from bridge

Behaviour:
- FSM states: IDLE, ADDR, DATA. Registers: state, owner (0=inst, 1=data), streak counter.
- Reset (rst=0, asynchronous): state=IDLE, owner=0, streak=0. While rst=0, all outputs are 0 (mem_req, mem_wr, mem_size, mem_addr, mem_wdata, all *_addr_ok, *_data_ok, *_rdata).
- Grant selection (IDLE only, combinational):
  - data_req & ~(inst_req & streak==MAX_DATA_STREAK & MAX_DATA_STREAK!=0) -> data.
  - Otherwise inst_req -> inst.
  - Otherwise no grant.
- IDLE with a grant:
  - mem_* = selected master's fields in the same cycle; mem_req=1.
  - sel_addr_ok = mem_addr_ok.
  - mem_addr_ok=1 -> DATA. Otherwise -> ADDR.
  - owner <= selected master in both cases.
- IDLE without a grant: mem_req=0, stay in IDLE.
- ADDR:
  - mem_* driven live from the owner's inputs; mem_req = owner's req.
  - Owner is locked; the other master sees addr_ok=0 even if it has higher priority.
  - mem_addr_ok=1 -> DATA.
  - Owner's req drops -> IDLE (protocol violation tolerated, no transaction counted).
- DATA:
  - mem_req=0; both *_addr_ok=0.
  - On mem_data_ok: owner's *_data_ok=1 for exactly that cycle, then -> IDLE.
  - A new grant is not issued in the same cycle; minimum spacing between accepts is 2 cycles.
- inst_rdata = data_rdata = mem_rdata at all times outside reset; only data_ok qualifies it.
- Streak counter, updated on each accept (addr_ok handshake):
  - data accept with inst_req=1: streak <= streak+1, saturating at MAX_DATA_STREAK.
  - data accept with inst_req=0: streak <= 0.
  - inst accept: streak <= 0.
- Boundary cases:
  - mem_data_ok in IDLE/ADDR (stale response after reset): ignored; no *_data_ok emitted.
  - mem_addr_ok while mem_req=0: ignored.
  - Both reqs arrive in the same cycle as reset deassertion: the grant is evaluated on the first cycle with rst=1.
  - Reset asserted mid-transaction: immediate return to IDLE, outputs 0; the pending transaction is abandoned.
- Non-owner *_addr_ok and *_data_ok are 0 in every state.

Test Plan:
1. Single inst read, bridge addr_ok same cycle, data_ok 2 cycles later with rdata=32'h24020001 -> inst_addr_ok at cycle 0, inst_data_ok exactly 1 cycle at cycle 2 with inst_rdata=32'h24020001, data_data_ok never asserted.
2. inst_req and data_req both asserted in IDLE, MAX_DATA_STREAK=4 -> data granted first (mem_addr=data_addr, mem_wr=data_wr). inst granted in the IDLE cycle after data_data_ok.
3. Both masters requesting continuously, data reissued after each completion -> grant order D,D,D,D,I,D,D,D,D,I. streak resets to 0 after each inst grant.
4. mem_addr_ok held low 3 cycles while owner=inst, data_req raised in cycle 1 -> mem_addr stays inst_addr, data_addr_ok=0 throughout. Inst accepted on cycle 3.
5. Data write (wr=1, size=0, addr=32'hbfaf0000, wdata=32'h000000ab) -> mem_* match exactly during the ADDR handshake. data_data_ok pulses once.
6. Reset asserted while in DATA, then a spurious mem_data_ok after release -> all outputs 0 during reset, no *_data_ok after release, next inst_req granted normally.
